// File: rtl/mr_pkg.sv
// Shared state, opcode, branch-condition and control-word definitions for the
// Maquina Rudimentaria control unit.
package mr_pkg;

    typedef enum logic [2:0] {
        RST_PC = 3'd0,
        IDLE   = 3'd1,
        FETCH  = 3'd2,
        DECODE = 3'd3,
        EX_LD  = 3'd4,
        EX_ST  = 3'd5,
        EX_BR  = 3'd6,
        EX_ALU = 3'd7
    } state_t;

    localparam logic [1:0] OP_LD  = 2'b00;
    localparam logic [1:0] OP_ST  = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;
    localparam logic [1:0] OP_ALU = 2'b11;

    localparam logic [2:0] BR  = 3'b000;
    localparam logic [2:0] BEQ = 3'b001;
    localparam logic [2:0] BL  = 3'b010;
    localparam logic [2:0] BLE = 3'b011;
    localparam logic [2:0] BNV = 3'b100;
    localparam logic [2:0] BNE = 3'b101;
    localparam logic [2:0] BG  = 3'b110;
    localparam logic [2:0] BGE = 3'b111;

    typedef struct packed {
        logic ld_ir;
        logic ld_rdir;
        logic ld_pc;
        logic mux_1_pc;
        logic reset_pc_sel;
        logic mem_w;
        logic sel_rb;
        logic ld_reg;
        logic sel_wsrc;
        logic ld_flags;
        logic instr_done;
    } ctrl_t;

endpackage

// File: rtl/mr_branch_eval.sv
// Branch condition evaluation: IR[13:11] against the Z/N flags.
// Purely combinational; no state, no flow control.
module mr_branch_eval
    import mr_pkg::*;
(
    input  logic [2:0] ir_cond,
    input  logic       flag_z,
    input  logic       flag_n,
    output logic       taken
);

    always_comb begin
        taken = 1'b0;
        case (ir_cond)
            BR:      taken = 1'b1;
            BEQ:     taken = flag_z;
            BL:      taken = flag_n;
            BLE:     taken = flag_n | flag_z;
            BNV:     taken = 1'b0;
            BNE:     taken = ~flag_z;
            BG:      taken = ~flag_n & ~flag_z;
            BGE:     taken = ~flag_n;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/mr_control.sv
// Control FSM for the Maquina Rudimentaria: one micro-step per clock, strobes decoded from state.
// run is honoured only in IDLE, so an instruction in progress always completes.
module mr_control
    import mr_pkg::*;
#(
    parameter logic [7:0] RESET_ADDR = 8'd0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic [1:0] ir_op,
    input  logic [2:0] ir_cond,
    input  logic       flag_z,
    input  logic       flag_n,
    output logic       ld_ir,
    output logic       ld_rdir,
    output logic       ld_pc,
    output logic       mux_1_pc,
    output logic       reset_pc_sel,
    output logic       mem_w,
    output logic       sel_rb,
    output logic       ld_reg,
    output logic       sel_wsrc,
    output logic       ld_flags,
    output logic       instr_done
);

    // RESET_ADDR is applied on the datapath pc_in mux; the sequencing here is independent of it.
    if (RESET_ADDR != 8'd0) begin : g_nonzero_reset_addr
    end

    state_t state;
    state_t state_nxt;
    ctrl_t  ctrl;
    logic   taken;

    mr_branch_eval u_branch_eval (
        .ir_cond (ir_cond),
        .flag_z  (flag_z),
        .flag_n  (flag_n),
        .taken   (taken)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RST_PC;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = RST_PC;
        ctrl      = '0;
        case (state)
            RST_PC: begin
                ctrl.reset_pc_sel = 1'b1;
                ctrl.ld_pc        = 1'b1;
                state_nxt         = IDLE;
            end
            IDLE: begin
                state_nxt = run ? FETCH : IDLE;
            end
            FETCH: begin
                ctrl.ld_ir = 1'b1;
                ctrl.ld_pc = 1'b1;
                state_nxt  = DECODE;
            end
            DECODE: begin
                ctrl.ld_rdir = 1'b1;
                case (ir_op)
                    OP_LD:   state_nxt = EX_LD;
                    OP_ST:   state_nxt = EX_ST;
                    OP_BR:   state_nxt = EX_BR;
                    default: state_nxt = EX_ALU;
                endcase
            end
            EX_LD: begin
                ctrl.mux_1_pc   = 1'b1;
                ctrl.ld_reg     = 1'b1;
                ctrl.ld_flags   = 1'b1;
                ctrl.instr_done = 1'b1;
                state_nxt       = IDLE;
            end
            EX_ST: begin
                ctrl.mux_1_pc   = 1'b1;
                ctrl.sel_rb     = 1'b1;
                ctrl.mem_w      = 1'b1;
                ctrl.instr_done = 1'b1;
                state_nxt       = IDLE;
            end
            EX_BR: begin
                ctrl.instr_done = 1'b1;
                // A taken branch fetches its target now and goes straight to DECODE.
                if (taken) begin
                    ctrl.mux_1_pc = 1'b1;
                    ctrl.ld_ir    = 1'b1;
                    ctrl.ld_pc    = 1'b1;
                    state_nxt     = DECODE;
                end else begin
                    state_nxt = IDLE;
                end
            end
            EX_ALU: begin
                ctrl.ld_reg     = 1'b1;
                ctrl.sel_wsrc   = 1'b1;
                ctrl.ld_flags   = 1'b1;
                ctrl.instr_done = 1'b1;
                state_nxt       = IDLE;
            end
            default: state_nxt = RST_PC;
        endcase
        if (rst) begin
            ctrl = '0;
        end
    end

    assign ld_ir        = ctrl.ld_ir;
    assign ld_rdir      = ctrl.ld_rdir;
    assign ld_pc        = ctrl.ld_pc;
    assign mux_1_pc     = ctrl.mux_1_pc;
    assign reset_pc_sel = ctrl.reset_pc_sel;
    assign mem_w        = ctrl.mem_w;
    assign sel_rb       = ctrl.sel_rb;
    assign ld_reg       = ctrl.ld_reg;
    assign sel_wsrc     = ctrl.sel_wsrc;
    assign ld_flags     = ctrl.ld_flags;
    assign instr_done   = ctrl.instr_done;

endmodule

// File: tb/tb_mr_control.sv
// Directed bench: a small MR datapath (RAM, IR, RDIR, PC, registers, flags) driven by the
// control strobes, with the control word and datapath state checked each micro-step.
module tb_mr_control;

    localparam logic [10:0] E_IDLE  = 11'h000;
    localparam logic [10:0] E_RST   = 11'h140;
    localparam logic [10:0] E_FETCH = 11'h500;
    localparam logic [10:0] E_DEC   = 11'h200;
    localparam logic [10:0] E_LD    = 11'h08B;
    localparam logic [10:0] E_ST    = 11'h0B1;
    localparam logic [10:0] E_BRT   = 11'h581;
    localparam logic [10:0] E_BRN   = 11'h001;
    localparam logic [10:0] E_ALU   = 11'h00F;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       run = 1'b0;
    logic [1:0] ir_op;
    logic [2:0] ir_cond;
    logic       flag_z = 1'b0;
    logic       flag_n = 1'b0;
    logic       ld_ir, ld_rdir, ld_pc, mux_1_pc, reset_pc_sel, mem_w;
    logic       sel_rb, ld_reg, sel_wsrc, ld_flags, instr_done;
    logic [10:0] outs;

    int checks = 0;
    int errors = 0;

    mr_control #(.RESET_ADDR(8'd0)) dut (
        .clk          (clk),
        .rst          (rst),
        .run          (run),
        .ir_op        (ir_op),
        .ir_cond      (ir_cond),
        .flag_z       (flag_z),
        .flag_n       (flag_n),
        .ld_ir        (ld_ir),
        .ld_rdir      (ld_rdir),
        .ld_pc        (ld_pc),
        .mux_1_pc     (mux_1_pc),
        .reset_pc_sel (reset_pc_sel),
        .mem_w        (mem_w),
        .sel_rb       (sel_rb),
        .ld_reg       (ld_reg),
        .sel_wsrc     (sel_wsrc),
        .ld_flags     (ld_flags),
        .instr_done   (instr_done)
    );

    always #5 clk = ~clk;

    assign outs = {ld_ir, ld_rdir, ld_pc, mux_1_pc, reset_pc_sel, mem_w,
                   sel_rb, ld_reg, sel_wsrc, ld_flags, instr_done};

    // Datapath model
    logic [15:0] mem [0:255];
    logic [15:0] r [0:7];
    logic [15:0] ir = 16'h0;
    logic [7:0]  pc = 8'hAA;
    logic [7:0]  rdir = 8'h00;
    logic [7:0]  mem_dir;
    logic [15:0] mem_out, regb_out, alu_out, wb;

    assign ir_op   = ir[15:14];
    assign ir_cond = ir[13:11];

    always_comb begin
        mem_dir  = mux_1_pc ? rdir : pc;
        mem_out  = mem[mem_dir];
        regb_out = sel_rb ? r[ir[13:11]] : r[ir[10:8]];
        alu_out  = r[ir[10:8]] - r[ir[7:5]];
        wb       = sel_wsrc ? alu_out : mem_out;
    end

    always @(posedge clk) begin
        if (ld_ir)   ir <= mem_out;
        if (ld_pc)   pc <= reset_pc_sel ? 8'h00 : mem_dir + 8'd1;
        if (ld_rdir) rdir <= regb_out[7:0] + ir[7:0];
        if (mem_w)   mem[mem_dir] <= regb_out;
        if (ld_reg)  r[ir[13:11]] <= wb;
        if (ld_flags) begin
            flag_z <= (wb == 16'h0);
            flag_n <= wb[15];
        end
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag, input logic [10:0] exp);
        @(negedge clk);
        chk(tag, {5'b0, outs}, {5'b0, exp});
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0;
        for (int i = 0; i < 8; i++) r[i] = 16'h0;
        mem[8'h00] = 16'h0805;  // LOAD R1 <= mem[R0+5]
        mem[8'h01] = 16'h4810;  // STORE R1 -> mem[0x10]
        mem[8'h02] = 16'h1006;  // LOAD R2 <= mem[6]
        mem[8'h03] = 16'h8820;  // BEQ 0x20
        mem[8'h04] = 16'h8040;  // BR 0x40
        mem[8'h05] = 16'h1234;
        mem[8'h06] = 16'h0000;
        mem[8'h07] = 16'hBEEF;
        mem[8'h20] = 16'h1807;  // LOAD R3 <= mem[7]
        mem[8'h21] = 16'h4806;  // STORE R1 -> mem[6]
        mem[8'h22] = 16'h5811;  // STORE R3 -> mem[0x11]
        mem[8'h40] = 16'hE160;  // R4 <= R1 - R3
        mem[8'h41] = 16'h9030;  // BL 0x30
        mem[8'h42] = 16'h80FF;  // BR 0xFF
        mem[8'hFF] = 16'hA000;  // BNV

        step("rst_outs_a", E_IDLE);
        step("rst_outs_b", E_IDLE);
        rst = 1'b0;
        run = 1'b1;
        #1;
        chk("rst_pc_outs", {5'b0, outs}, {5'b0, E_RST});
        step("idle_after_rst", E_IDLE);
        chk("pc_reset", {8'h0, pc}, 16'h0000);

        step("fetch_ld", E_FETCH);
        step("dec_ld", E_DEC);
        chk("ir_ld", ir, 16'h0805);
        step("ex_ld", E_LD);
        chk("rdir_ld", {8'h0, rdir}, 16'h0005);
        step("idle_ld", E_IDLE);
        chk("r1_ld", r[1], 16'h1234);

        step("fetch_st", E_FETCH);
        step("dec_st", E_DEC);
        step("ex_st", E_ST);
        chk("rdir_st", {8'h0, rdir}, 16'h0010);
        step("idle_st", E_IDLE);
        chk("mem10_st", mem[8'h10], 16'h1234);

        step("fetch_ld2", E_FETCH);
        step("dec_ld2", E_DEC);
        step("ex_ld2", E_LD);
        step("idle_ld2", E_IDLE);
        chk("flag_z_set", {15'h0, flag_z}, 16'h0001);

        step("fetch_beq", E_FETCH);
        step("dec_beq", E_DEC);
        chk("pc_beq", {8'h0, pc}, 16'h0004);
        step("ex_beq_taken", E_BRT);
        step("dec_after_taken", E_DEC);
        chk("pc_taken", {8'h0, pc}, 16'h0021);
        chk("ir_taken", ir, 16'h1807);
        run = 1'b0;
        step("ex_ld_stall", E_LD);
        step("idle_stall_a", E_IDLE);
        step("idle_stall_b", E_IDLE);
        chk("pc_stall", {8'h0, pc}, 16'h0021);
        chk("r3_ld", r[3], 16'hBEEF);
        chk("flag_n_set", {15'h0, flag_n}, 16'h0001);
        run = 1'b1;

        step("fetch_resume", E_FETCH);
        step("dec_st6", E_DEC);
        step("ex_st6", E_ST);
        step("idle_st6", E_IDLE);
        chk("mem6_st", mem[8'h06], 16'h1234);

        step("fetch_st11", E_FETCH);
        step("dec_st11", E_DEC);
        step("ex_st11", E_ST);
        rst = 1'b1;
        #1;
        chk("rst_in_ex_st", {5'b0, outs}, {5'b0, E_IDLE});
        step("rst_hold", E_IDLE);
        chk("mem11_no_write", mem[8'h11], 16'h0000);
        rst = 1'b0;
        #1;
        chk("rst_pc_again", {5'b0, outs}, {5'b0, E_RST});
        step("idle_rst2", E_IDLE);
        chk("pc_reset2", {8'h0, pc}, 16'h0000);

        step("fetch_ld_p2", E_FETCH);
        step("dec_ld_p2", E_DEC);
        step("ex_ld_p2", E_LD);
        step("idle_ld_p2", E_IDLE);
        step("fetch_st_p2", E_FETCH);
        step("dec_st_p2", E_DEC);
        step("ex_st_p2", E_ST);
        step("idle_st_p2", E_IDLE);
        step("fetch_ld2_p2", E_FETCH);
        step("dec_ld2_p2", E_DEC);
        step("ex_ld2_p2", E_LD);
        step("idle_ld2_p2", E_IDLE);
        chk("flag_z_clear", {15'h0, flag_z}, 16'h0000);

        step("fetch_beq_p2", E_FETCH);
        step("dec_beq_p2", E_DEC);
        step("ex_beq_not_taken", E_BRN);
        step("idle_not_taken", E_IDLE);
        chk("pc_not_taken", {8'h0, pc}, 16'h0004);

        step("fetch_br", E_FETCH);
        step("dec_br", E_DEC);
        step("ex_br_always", E_BRT);
        step("dec_alu", E_DEC);
        chk("pc_alu", {8'h0, pc}, 16'h0041);
        step("ex_alu", E_ALU);
        step("idle_alu", E_IDLE);
        chk("r4_alu", r[4], 16'h5345);
        chk("flag_n_alu", {15'h0, flag_n}, 16'h0000);

        step("fetch_bl", E_FETCH);
        step("dec_bl", E_DEC);
        step("ex_bl_not_taken", E_BRN);
        step("idle_bl", E_IDLE);

        step("fetch_br_ff", E_FETCH);
        step("dec_br_ff", E_DEC);
        step("ex_br_ff", E_BRT);
        step("dec_bnv", E_DEC);
        chk("pc_wrap", {8'h0, pc}, 16'h0000);
        chk("ir_ff", ir, 16'hA000);
        run = 1'b0;
        step("ex_bnv", E_BRN);
        step("idle_end_a", E_IDLE);
        step("idle_end_b", E_IDLE);
        chk("pc_end", {8'h0, pc}, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
